// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo position controller.
// No ports; imported by servo_debounce and servo_position_ctrl.
package servo_pkg;

   localparam int unsigned PW_W  = 17;
   localparam int unsigned CNT_W = 20;

   localparam int unsigned DEF_FRAME_CNT = 1_000_000;
   localparam int unsigned DEF_MIN_PW    = 50_000;
   localparam int unsigned DEF_MAX_PW    = 100_000;
   localparam int unsigned DEF_CENTER_PW = 75_000;
   localparam int unsigned DEF_STEP_PW   = 500;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FIRST,
      ST_HOLD,
      ST_REPEAT
   } state_t;

   typedef enum logic [1:0] {
      DIR_NONE,
      DIR_R,
      DIR_L
   } dir_t;

endpackage

// File: rtl/servo_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer.
// Ports: clk, rst_n (sync, active-low), btn_raw (async raw level),
//        level (debounced level, 1 = released after reset).
module servo_debounce
   import servo_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CNT = 500_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic level
);

   localparam int unsigned DB_W = $clog2(DEBOUNCE_CNT + 1);

   logic [1:0]      sync;
   logic [DB_W-1:0] stable_cnt;

   // Level flips on the DEBOUNCE_CNT-th consecutive clock that disagrees with it;
   // any clock that agrees again restarts the count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync       <= 2'b11;
         level      <= 1'b1;
         stable_cnt <= '0;
      end else begin
         sync <= {sync[0], btn_raw};
         if (sync[1] == level) begin
            stable_cnt <= '0;
         end else if (stable_cnt == DB_W'(DEBOUNCE_CNT - 1)) begin
            level      <= sync[1];
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + DB_W'(1);
         end
      end
   end

endmodule

// File: rtl/servo_position_ctrl.sv
// Servo PWM controller: debounced buttons step the pulse width at frame
// boundaries, with auto-repeat after a hold delay and a center request.
// Ports: clk, rst_n (sync, active-low), button_R/button_L (raw, 0 = pressed),
//        center_req (1-cycle), servo (PWM out), pulse_width (width in effect),
//        frame_start (strobe after cnt==0), at_limit (pulse_width at MIN/MAX).
module servo_position_ctrl
   import servo_pkg::*;
#(
   parameter int unsigned FRAME_CNT    = DEF_FRAME_CNT,
   parameter int unsigned MIN_PW       = DEF_MIN_PW,
   parameter int unsigned MAX_PW       = DEF_MAX_PW,
   parameter int unsigned CENTER_PW    = DEF_CENTER_PW,
   parameter int unsigned STEP_PW      = DEF_STEP_PW,
   parameter int unsigned DEBOUNCE_CNT = 500_000,
   parameter int unsigned REPEAT_DELAY = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            button_R,
   input  logic            button_L,
   input  logic            center_req,
   output logic            servo,
   output logic [PW_W-1:0] pulse_width,
   output logic            frame_start,
   output logic            at_limit
);

   localparam int unsigned HOLD_W = $clog2(REPEAT_DELAY + 1);
   localparam int unsigned WIDE_W = PW_W + 1;

   logic              db_r, db_l;
   dir_t              dir_cur, pend_dir;
   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt;
   logic [CNT_W-1:0]  cnt;
   logic              center_pend;
   logic              boundary;
   logic              load_dir, apply_step, hold_clr, hold_inc;
   logic [WIDE_W-1:0] pw_sum, pw_diff;
   logic [PW_W-1:0]   pw_step, pw_next;

   servo_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_r (
      .clk(clk), .rst_n(rst_n), .btn_raw(button_R), .level(db_r)
   );

   servo_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_l (
      .clk(clk), .rst_n(rst_n), .btn_raw(button_L), .level(db_l)
   );

   assign boundary = (cnt == CNT_W'(FRAME_CNT - 1));

   // Exactly one button pressed gives a direction; both or neither gives none.
   always_comb begin
      dir_cur = DIR_NONE;
      case ({db_r, db_l})
         2'b01:   dir_cur = DIR_R;
         2'b10:   dir_cur = DIR_L;
         default: dir_cur = DIR_NONE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state; a center at the boundary always returns to IDLE
   always_comb begin
      state_d = state_q;
      if (boundary && center_pend) begin
         state_d = ST_IDLE;
      end else if (state_q == ST_IDLE) begin
         if (dir_cur != DIR_NONE) state_d = ST_FIRST;
      end else if (dir_cur == DIR_NONE) begin
         state_d = ST_IDLE;
      end else if (dir_cur != pend_dir) begin
         state_d = ST_FIRST;
      end else if (boundary) begin
         if (state_q == ST_FIRST) begin
            state_d = ST_HOLD;
         end else if (state_q == ST_HOLD && hold_cnt == HOLD_W'(REPEAT_DELAY - 1)) begin
            state_d = ST_REPEAT;
         end
      end
   end

   // FSM outputs: direction capture, step strobe, hold counter control
   always_comb begin
      load_dir   = 1'b0;
      apply_step = 1'b0;
      hold_clr   = 1'b0;
      hold_inc   = 1'b0;
      if (state_q == ST_IDLE) begin
         load_dir = (dir_cur != DIR_NONE);
      end else if (dir_cur != DIR_NONE && dir_cur != pend_dir) begin
         load_dir = 1'b1;
      end
      if (boundary && !center_pend && state_q != ST_IDLE &&
          dir_cur != DIR_NONE && dir_cur == pend_dir) begin
         case (state_q)
            ST_FIRST: begin
               apply_step = 1'b1;
               hold_clr   = 1'b1;
            end
            ST_HOLD:   hold_inc   = 1'b1;
            ST_REPEAT: apply_step = 1'b1;
            default:   ;
         endcase
      end
   end

   // Saturating step; the extra bit catches both overflow and underflow
   assign pw_sum  = {1'b0, pulse_width} + WIDE_W'(STEP_PW);
   assign pw_diff = {1'b0, pulse_width} - WIDE_W'(STEP_PW);

   always_comb begin
      pw_step = pulse_width;
      if (pend_dir == DIR_R) begin
         pw_step = (pw_sum > WIDE_W'(MAX_PW)) ? PW_W'(MAX_PW) : pw_sum[PW_W-1:0];
      end else if (pend_dir == DIR_L) begin
         pw_step = (pw_diff[WIDE_W-1] || pw_diff < WIDE_W'(MIN_PW)) ?
                   PW_W'(MIN_PW) : pw_diff[PW_W-1:0];
      end
   end

   always_comb begin
      pw_next = pulse_width;
      if (boundary && center_pend) pw_next = PW_W'(CENTER_PW);
      else if (apply_step)         pw_next = pw_step;
   end

   // Frame counter, PWM output and pulse-width datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt         <= '0;
         servo       <= 1'b0;
         frame_start <= 1'b0;
         at_limit    <= 1'b0;
         pulse_width <= PW_W'(CENTER_PW);
         pend_dir    <= DIR_NONE;
         center_pend <= 1'b0;
         hold_cnt    <= '0;
      end else begin
         cnt         <= boundary ? '0 : cnt + CNT_W'(1);
         frame_start <= (cnt == '0);
         servo       <= (cnt < CNT_W'(pulse_width));
         pulse_width <= pw_next;
         at_limit    <= (pw_next == PW_W'(MIN_PW)) || (pw_next == PW_W'(MAX_PW));
         center_pend <= center_req || (center_pend && !boundary);
         if (load_dir) pend_dir <= dir_cur;
         if (hold_clr)      hold_cnt <= '0;
         else if (hold_inc) hold_cnt <= hold_cnt + HOLD_W'(1);
      end
   end

endmodule

// File: tb/tb_servo_position_ctrl.sv
// Frame-level self-checking bench for servo_position_ctrl.
module tb_servo_position_ctrl;

   localparam int unsigned FRAME = 1000;
   localparam int unsigned MINP  = 50;
   localparam int unsigned MAXP  = 100;
   localparam int unsigned CENTP = 75;
   localparam int unsigned STEPP = 5;
   localparam int unsigned DEB   = 8;
   localparam int unsigned RPT   = 3;

   logic        clk;
   logic        rst_n;
   logic        button_R;
   logic        button_L;
   logic        center_req;
   logic        servo;
   logic [16:0] pulse_width;
   logic        frame_start;
   logic        at_limit;

   int n_cmp;
   int n_bad;

   // reference model: pulse width in effect, direction held at the last
   // boundary, and boundaries since that direction was first acted on
   int m_pw;
   int m_prev;
   int m_hold;
   bit cur_r;
   bit cur_l;

   servo_position_ctrl #(
      .FRAME_CNT(FRAME), .MIN_PW(MINP), .MAX_PW(MAXP), .CENTER_PW(CENTP),
      .STEP_PW(STEPP), .DEBOUNCE_CNT(DEB), .REPEAT_DELAY(RPT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .button_R(button_R), .button_L(button_L),
      .center_req(center_req), .servo(servo), .pulse_width(pulse_width),
      .frame_start(frame_start), .at_limit(at_limit)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int dir_of(input bit r, input bit l);
      if (!r && l) return 1;
      if (r && !l) return 2;
      return 0;
   endfunction

   function automatic int lim(input int pw);
      return (pw == int'(MINP) || pw == int'(MAXP)) ? 1 : 0;
   endfunction

   // Behaviour at a frame boundary: first boundary of a held direction steps,
   // the next RPT boundaries hold, later boundaries step every frame.
   task automatic model_boundary(input int d, input bit ctr);
      if (ctr) begin
         m_pw   = int'(CENTP);
         m_prev = 0;
         m_hold = 0;
      end else if (d == 0) begin
         m_prev = 0;
         m_hold = 0;
      end else begin
         if (d != m_prev) m_hold = 0;
         if (m_hold == 0 || m_hold > int'(RPT)) begin
            if (d == 1) m_pw = (m_pw + int'(STEPP) > int'(MAXP)) ? int'(MAXP) : m_pw + int'(STEPP);
            else        m_pw = (m_pw - int'(STEPP) < int'(MINP)) ? int'(MINP) : m_pw - int'(STEPP);
         end
         m_hold++;
         m_prev = d;
      end
   endtask

   task automatic model_reset();
      m_pw   = int'(CENTP);
      m_prev = 0;
      m_hold = 0;
   endtask

   // One full frame: new raw levels from chg_at, optional short glitch on one
   // button, optional center pulse; checks PWM duty, strobe and boundary update.
   task automatic run_frame(input string tag, input bit new_r, input bit new_l,
                            input int chg_at, input int g_at, input int g_len,
                            input bit g_on_r, input int ctr_at);
      int hi;
      int fs;
      int pw_cur;
      hi = 0;
      fs = 0;
      pw_cur = m_pw;
      for (int i = 1; i <= int'(FRAME); i++) begin
         @(negedge clk);
         if (servo) hi++;
         if (frame_start) fs++;
         if (i == 1) check_eq({tag, " frame_start_first"}, int'(frame_start), 1);
         if (i == int'(FRAME) / 2) check_eq({tag, " pw_mid"}, int'(pulse_width), pw_cur);
         if (i == int'(FRAME)) begin
            model_boundary(dir_of(cur_r, cur_l), ctr_at > 0);
            check_eq({tag, " pw_next"}, int'(pulse_width), m_pw);
            check_eq({tag, " at_limit"}, int'(at_limit), lim(m_pw));
         end
         if (chg_at > 0 && i >= chg_at) begin
            cur_r = new_r;
            cur_l = new_l;
         end
         button_R = cur_r;
         button_L = cur_l;
         if (g_len > 0 && i >= g_at && i < g_at + g_len) begin
            if (g_on_r) button_R = ~cur_r;
            else        button_L = ~cur_l;
         end
         center_req = (i == ctr_at);
      end
      check_eq({tag, " servo_high"}, hi, pw_cur);
      check_eq({tag, " frame_starts"}, fs, 1);
   endtask

   // Reset asserted at frame position `at`; then a clean restart from cnt=0.
   task automatic reset_mid(input int at);
      for (int i = 1; i <= at; i++) @(negedge clk);
      check_eq("rst_mid servo_before", int'(servo), 1);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("rst_mid servo", int'(servo), 0);
      check_eq("rst_mid pw", int'(pulse_width), int'(CENTP));
      check_eq("rst_mid frame_start", int'(frame_start), 0);
      check_eq("rst_mid at_limit", int'(at_limit), 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      cur_r      = 1'b1;
      cur_l      = 1'b1;
      rst_n      = 1'b0;
      button_R   = 1'b1;
      button_L   = 1'b1;
      center_req = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_eq("reset servo", int'(servo), 0);
      check_eq("reset pw", int'(pulse_width), int'(CENTP));
      check_eq("reset frame_start", int'(frame_start), 0);
      check_eq("reset at_limit", int'(at_limit), 0);
      rst_n = 1'b1;

      // idle frames at center
      run_frame("t1_idle0", 1, 1, -1, 0, 0, 0, -1);
      run_frame("t1_idle1", 1, 1, -1, 0, 0, 0, -1);

      // bounce ignored, one-frame hold gives one step, release stops stepping
      run_frame("t2_bounce", 1, 1, -1, 100, 3, 1, -1);
      run_frame("t2_hold",   0, 1, 100, 0, 0, 0, -1);
      run_frame("t2_rel",    1, 1, 100, 0, 0, 0, -1);
      run_frame("t2_center", 1, 1, -1, 0, 0, 0, 400);

      // left held: first step, hold delay, repeat, saturation at MIN
      run_frame("t3_l0", 1, 0, 100, 0, 0, 0, -1);
      for (int f = 1; f < 10; f++) run_frame($sformatf("t3_l%0d", f), 1, 0, -1, 0, 0, 0, -1);
      run_frame("t3_rel", 1, 1, 100, 0, 0, 0, -1);

      // both pressed is no direction; releasing L leaves R
      run_frame("t4_both0", 0, 0, 100, 0, 0, 0, -1);
      run_frame("t4_both1", 0, 0, -1, 0, 0, 0, -1);
      run_frame("t4_rel_l", 0, 1, 100, 0, 0, 0, -1);

      // right held to MAX, then center while still held
      for (int f = 0; f < 20 && m_pw != int'(MAXP); f++)
         run_frame($sformatf("t5_up%0d", f), 0, 1, -1, 0, 0, 0, -1);
      run_frame("t5_sat",   0, 1, -1, 0, 0, 0, -1);
      run_frame("t5_ctr",   0, 1, -1, 0, 0, 0, 300);
      run_frame("t5_after", 0, 1, -1, 0, 0, 0, -1);

      // reset mid-frame at cnt=40
      for (int f = 0; f < 12 && m_pw != 90; f++)
         run_frame($sformatf("t6_up%0d", f), 0, 1, -1, 0, 0, 0, -1);
      check_eq("t6 pw_before_reset", int'(pulse_width), 90);
      reset_mid(40);
      run_frame("t6_post", 0, 1, -1, 0, 0, 0, -1);
      run_frame("t6_rel",  1, 1, 100, 0, 0, 0, -1);

      // randomized frames
      for (int f = 0; f < 14; f++) begin
         bit r;
         bit l;
         int chg;
         int g_len;
         int ctr;
         r     = 1'($urandom_range(0, 1));
         l     = 1'($urandom_range(0, 1));
         chg   = int'($urandom_range(20, 600));
         g_len = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : 0;
         ctr   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 900)) : -1;
         run_frame($sformatf("rnd%0d", f), r, l, chg, int'($urandom_range(650, 850)),
                   g_len, 1'($urandom_range(0, 1)), ctr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
